bcd_display_scanner: RTL and testbench

- Downstream consumer of the BCD up-counter chain: takes NUM_DIGITS packed BCD digits and drives a multiplexed, common-anode seven-segment display.
- Captures new digit values on a load strobe and commits them only at frame boundaries, so a display frame never shows a mix of old and new digits.
- Scans one digit per refresh period and decodes BCD to segments.
- Blanks leading zeros and shows a dash for non-BCD codes.

---
 rtl/bcd_display_scanner.sv | 142 ++++++++++++++
 tb/tb_bcd_display_scanner.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
// Scans NUM_DIGITS shadowed BCD digits onto a common-anode 7-segment display, one digit per refresh period.
// Latency: an/seg/dp are registered, one cycle behind the scan index and shadow digits; frame_done is registered.
// Backpressure: none; loads are held pending and committed only at frame boundaries or while disabled.
module bcd_display_scanner #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 100000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        refresh_cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow_digits;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [4*NUM_DIGITS-1:0] pending_digits;
    logic [NUM_DIGITS-1:0]   pending_dp;
    logic                    pending_valid;

    logic                    period_end;
    logic                    frame_wrap;
    logic                    commit;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    blank_run;
    logic [3:0]              cur_digit;
    logic [6:0]              seg_next;
    logic [NUM_DIGITS-1:0]   an_next;

    // Frame boundary: last digit's last refresh cycle; the shadow swap happens on this same edge.
    assign period_end = enable && (refresh_cnt == CNT_LAST);
    assign frame_wrap = period_end && (idx == IDX_LAST);
    assign commit     = frame_wrap || !enable;

    // Refresh counter and digit index; both parked at zero while disabled so a restart begins at digit 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            refresh_cnt <= '0;
            idx         <= '0;
        end else if (!enable) begin
            refresh_cnt <= '0;
            idx         <= '0;
        end else if (period_end) begin
            refresh_cnt <= '0;
            idx         <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            refresh_cnt <= refresh_cnt + CNT_W'(1);
        end
    end

    // Pending/shadow double buffer: a load coinciding with a commit bypasses pending so the newest value wins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow_digits  <= '0;
            shadow_dp      <= '0;
            pending_digits <= '0;
            pending_dp     <= '0;
            pending_valid  <= 1'b0;
        end else if (commit) begin
            pending_valid <= 1'b0;
            if (load) begin
                shadow_digits <= digits_in;
                shadow_dp     <= dp_in;
            end else if (pending_valid) begin
                shadow_digits <= pending_digits;
                shadow_dp     <= pending_dp;
            end
        end else if (load) begin
            pending_digits <= digits_in;
            pending_dp     <= dp_in;
            pending_valid  <= 1'b1;
        end
    end

    // Leading-zero run from the top digit down; a non-zero or invalid code ends the run, digit 0 never blanks.
    always_comb begin
        blank     = '0;
        blank_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            blank_run = blank_run && (shadow_digits[4*k +: 4] == 4'd0);
            blank[k]  = blank_run && (BLANK_LEADING != 0);
        end
    end

    // BCD to active-low {g,f,e,d,c,b,a}; non-BCD codes render a dash.
    always_comb begin
        cur_digit = shadow_digits[{idx, 2'b00} +: 4];
        case (cur_digit)
            4'd0:    seg_next = 7'b1000000;
            4'd1:    seg_next = 7'b1111001;
            4'd2:    seg_next = 7'b0100100;
            4'd3:    seg_next = 7'b0110000;
            4'd4:    seg_next = 7'b0011001;
            4'd5:    seg_next = 7'b0010010;
            4'd6:    seg_next = 7'b0000010;
            4'd7:    seg_next = 7'b1111000;
            4'd8:    seg_next = 7'b0000000;
            4'd9:    seg_next = 7'b0010000;
            default: seg_next = 7'b0111111;
        endcase
        if (blank[idx]) begin
            seg_next = 7'b1111111;
        end
        an_next      = '1;
        an_next[idx] = 1'b0;
    end

    // Registered display drive; disabled means every digit and segment off.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an         <= '1;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else if (!enable) begin
            an         <= '1;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= an_next;
            seg        <= seg_next;
            dp         <= ~shadow_dp[idx];
            frame_done <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with NUM_DIGITS=4, REFRESH_DIV=4, BLANK_LEADING=1.
// Latency: outputs sampled on the falling edge; digit k of a frame appears at samples 4k..4k+3 after frame_done.
// Backpressure: none; every wait on frame_done is bounded and a timeout counts as a failure.
module tb_bcd_display_scanner;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    logic [3:0] cap_an  [16];
    logic [6:0] cap_seg [16];
    logic       cap_dp  [16];
    logic       cap_fd  [16];

    bcd_display_scanner #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (4),
        .BLANK_LEADING(1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .digits_in (digits_in),
        .dp_in     (dp_in),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_done(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to the next falling edge on which frame_done is high, giving up after 40 cycles.
    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Record one full frame (16 falling edges) starting right after a frame_done sample.
    task automatic capture_frame();
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            cap_an[i]  = an;
            cap_seg[i] = seg;
            cap_dp[i]  = dp;
            cap_fd[i]  = frame_done;
        end
    endtask

    // One-cycle load strobe issued at the current falling edge.
    task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
        load      = 1'b1;
        digits_in = d;
        dp_in     = p;
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        total++;
        if (an !== 4'b1111) begin bad++; $display("FAIL reset_an got=%b exp=1111", an); end
        total++;
        if (seg !== 7'b1111111) begin bad++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
        total++;
        if (dp !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b exp=1", dp); end
        total++;
        if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd got=%b exp=0", frame_done); end
    endtask

    task automatic test_basic();
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an  [4];
        bit ok;
        exp_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        reset  = 1'b1;
        enable = 1'b1;
        pulse_load(16'h1234, 4'b0000);
        wait_frame(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_frame_wait got=timeout exp=frame_done"); end
        capture_frame();
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j += 3) begin
                total++;
                if (cap_an[4*k+j] !== exp_an[k]) begin
                    bad++; $display("FAIL basic_an d%0d s%0d got=%b exp=%b", k, j, cap_an[4*k+j], exp_an[k]);
                end
                total++;
                if (cap_seg[4*k+j] !== exp_seg[k]) begin
                    bad++; $display("FAIL basic_seg d%0d s%0d got=%b exp=%b", k, j, cap_seg[4*k+j], exp_seg[k]);
                end
            end
        end
        total++;
        if (cap_fd[0] !== 1'b0 || cap_fd[14] !== 1'b0) begin
            bad++; $display("FAIL basic_fd_gap got=%b%b exp=00", cap_fd[0], cap_fd[14]);
        end
        total++;
        if (cap_fd[15] !== 1'b1) begin bad++; $display("FAIL basic_fd_period got=%b exp=1", cap_fd[15]); end
    endtask

    task automatic test_blanking();
        logic [6:0] exp_a [4];
        logic [6:0] exp_b [4];
        bit ok;
        exp_a = '{7'b0100100, 7'b0011001, 7'b1111111, 7'b1111111};
        exp_b = '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111};
        pulse_load(16'h0042, 4'b0000);
        wait_frame(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL blank42_wait got=timeout exp=frame_done"); end
        capture_frame();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap_seg[4*k+1] !== exp_a[k]) begin
                bad++; $display("FAIL blank42_seg d%0d got=%b exp=%b", k, cap_seg[4*k+1], exp_a[k]);
            end
        end
        total++;
        if (cap_an[13] !== 4'b0111) begin bad++; $display("FAIL blank42_an3 got=%b exp=0111", cap_an[13]); end
        pulse_load(16'h0000, 4'b0000);
        wait_frame(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL blank00_wait got=timeout exp=frame_done"); end
        capture_frame();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap_seg[4*k+2] !== exp_b[k]) begin
                bad++; $display("FAIL blank00_seg d%0d got=%b exp=%b", k, cap_seg[4*k+2], exp_b[k]);
            end
        end
    endtask

    task automatic test_invalid_dp();
        logic [6:0] exp_seg [4];
        logic       exp_dp  [4];
        bit ok;
        exp_seg = '{7'b0010010, 7'b0111111, 7'b1111111, 7'b1111111};
        exp_dp  = '{1'b1, 1'b1, 1'b0, 1'b1};
        pulse_load(16'h00A5, 4'b0100);
        wait_frame(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL inv_wait got=timeout exp=frame_done"); end
        capture_frame();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap_seg[4*k] !== exp_seg[k]) begin
                bad++; $display("FAIL inv_seg d%0d got=%b exp=%b", k, cap_seg[4*k], exp_seg[k]);
            end
            total++;
            if (cap_dp[4*k] !== exp_dp[k]) begin
                bad++; $display("FAIL inv_dp d%0d got=%b exp=%b", k, cap_dp[4*k], exp_dp[k]);
            end
        end
    endtask

    task automatic test_no_tear();
        bit ok;
        wait_frame(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL tear_wait got=timeout exp=frame_done"); end
        repeat (5) @(negedge clock);
        pulse_load(16'h5555, 4'b0000);
        repeat (3) @(negedge clock);
        total++;
        if (seg !== 7'b1111111 || dp !== 1'b0) begin
            bad++; $display("FAIL tear_mid_d2 got=%b/%b exp=1111111/0", seg, dp);
        end
        repeat (4) @(negedge clock);
        total++;
        if (seg !== 7'b1111111) begin bad++; $display("FAIL tear_mid_d3 got=%b exp=1111111", seg); end
        wait_frame(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL tear_commit_wait got=timeout exp=frame_done"); end
        capture_frame();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap_seg[4*k+3] !== 7'b0010010 || cap_dp[4*k+3] !== 1'b1) begin
                bad++; $display("FAIL tear_new d%0d got=%b/%b exp=0010010/1", k, cap_seg[4*k+3], cap_dp[4*k+3]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        wait_frame(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_wait got=timeout exp=frame_done"); end
        repeat (5) @(negedge clock);
        load      = 1'b1;
        digits_in = 16'h1111;
        dp_in     = 4'b0000;
        @(negedge clock);
        digits_in = 16'h2222;
        @(negedge clock);
        load = 1'b0;
        wait_frame(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_commit_wait got=timeout exp=frame_done"); end
        capture_frame();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap_seg[4*k+1] !== 7'b0100100) begin
                bad++; $display("FAIL b2b_last_wins d%0d got=%b exp=0100100", k, cap_seg[4*k+1]);
            end
        end
        // Stale pending 6666 mid-frame, then 7777 on the wrap cycle itself.
        repeat (5) @(negedge clock);
        pulse_load(16'h6666, 4'b0000);
        repeat (9) @(negedge clock);
        load      = 1'b1;
        digits_in = 16'h7777;
        @(negedge clock);
        load = 1'b0;
        total++;
        if (frame_done !== 1'b1) begin bad++; $display("FAIL coinc_fd got=%b exp=1", frame_done); end
        capture_frame();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap_seg[4*k] !== 7'b1111000) begin
                bad++; $display("FAIL coinc_seg d%0d got=%b exp=1111000", k, cap_seg[4*k]);
            end
        end
        capture_frame();
        total++;
        if (cap_seg[5] !== 7'b1111000) begin bad++; $display("FAIL coinc_hold got=%b exp=1111000", cap_seg[5]); end
    endtask

    task automatic test_enable();
        bit ok;
        wait_frame(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL en_wait got=timeout exp=frame_done"); end
        repeat (5) @(negedge clock);
        pulse_load(16'h3333, 4'b0000);
        total++;
        if (an !== 4'b1101) begin bad++; $display("FAIL en_before_off got=%b exp=1101", an); end
        enable = 1'b0;
        @(negedge clock);
        total++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || frame_done !== 1'b0) begin
            bad++; $display("FAIL en_off got=%b/%b/%b/%b exp=1111/1111111/1/0", an, seg, dp, frame_done);
        end
        repeat (3) @(negedge clock);
        total++;
        if (an !== 4'b1111) begin bad++; $display("FAIL en_off_hold got=%b exp=1111", an); end
        enable = 1'b1;
        capture_frame();
        total++;
        if (cap_an[0] !== 4'b1110 || cap_seg[0] !== 7'b0110000) begin
            bad++; $display("FAIL en_restart got=%b/%b exp=1110/0110000", cap_an[0], cap_seg[0]);
        end
        total++;
        if (cap_an[3] !== 4'b1110 || cap_an[4] !== 4'b1101) begin
            bad++; $display("FAIL en_full_period got=%b/%b exp=1110/1101", cap_an[3], cap_an[4]);
        end
        total++;
        if (cap_fd[14] !== 1'b0 || cap_fd[15] !== 1'b1) begin
            bad++; $display("FAIL en_fd got=%b%b exp=01", cap_fd[14], cap_fd[15]);
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] exp_seg [4];
        bit ok;
        exp_seg = '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111};
        repeat (5) @(negedge clock);
        pulse_load(16'h9999, 4'b1111);
        reset = 1'b0;
        #1;
        total++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || frame_done !== 1'b0) begin
            bad++; $display("FAIL rst_mid got=%b/%b/%b/%b exp=1111/1111111/1/0", an, seg, dp, frame_done);
        end
        @(negedge clock);
        reset = 1'b1;
        wait_frame(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL rst_mid_wait got=timeout exp=frame_done"); end
        capture_frame();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap_seg[4*k] !== exp_seg[k] || cap_dp[4*k] !== 1'b1) begin
                bad++; $display("FAIL rst_mid_shadow d%0d got=%b/%b exp=%b/1", k, cap_seg[4*k], cap_dp[4*k], exp_seg[k]);
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        load      = 1'b0;
        digits_in = 16'h0000;
        dp_in     = 4'b0000;
        test_reset();
        test_basic();
        test_blanking();
        test_invalid_dp();
        test_no_tear();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
